rd_data_path: RTL

RD_DATA_PATH -- requirements
Module: rd_data_path

---
 rtl/rd_path_pkg.sv | 23 ++
 rtl/rd_fifo.sv | 51 +++++
 rtl/rd_data_path.sv | 105 ++++++++++
 3 files changed

// File: rtl/rd_path_pkg.sv
// Shared types and defaults for the read data path: FSM state encoding,
// default burst geometry and a constant-foldable ceil(log2) helper.
package rd_path_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CL = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_BL     = 8;
  localparam int DEF_CL     = 5;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int x = value - 1; x > 0; x = x >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/rd_fifo.sv
// First-word-fall-through FIFO: head word visible combinationally from the
// storage array; pointers carry one extra wrap bit so full/empty are unambiguous.
module rd_fifo
  import rd_path_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [AW:0]       count
);

  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = wptr - rptr;
  // Gated so the head reads zero whenever nothing valid is held (incl. reset).
  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rd_data_path.sv
// Read burst capture: waits CL cycles after an accepted command, then writes BL
// beats into rd_fifo. Optional RD_PARITY_EN adds dq_par input and sticky par_err.
module rd_data_path
  import rd_path_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BL     = DEF_BL,
  parameter int CL     = DEF_CL,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_cmd,
  output logic              rd_cmd_ready,
  input  logic [DATA_W-1:0] dq_in,
`ifdef RD_PARITY_EN
  input  logic              dq_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              burst_done
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (BL > 1) ? clog2(BL) : 1;

  localparam logic [CW-1:0] MAX_FILL  = CW'(DEPTH - BL);
  localparam logic [3:0]    LAT_INIT  = 4'(CL - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BL - 1);

  state_t        state;
  logic [3:0]    lat;
  logic [BW-1:0] beat;
  logic [AW:0]   fifo_count;
  logic          push;
  logic          pop;

  // Admission guarantees room for a whole burst, so capture never stalls.
  assign rd_cmd_ready = (state == IDLE) && (fifo_count <= MAX_FILL);
  assign push         = (state == CAPTURE);
  assign rd_valid     = (fifo_count != '0);
  assign pop          = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat        <= '0;
      beat       <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_cmd && rd_cmd_ready) begin
            state <= WAIT_CL;
            lat   <= LAT_INIT;
          end
        end
        WAIT_CL: begin
          if (lat <= 4'd1) begin
            state <= CAPTURE;
            lat   <= '0;
            beat  <= '0;
          end else begin
            lat <= lat - 4'd1;
          end
        end
        CAPTURE: begin
          if (beat == LAST_BEAT) begin
            state      <= IDLE;
            beat       <= '0;
            burst_done <= 1'b1;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RD_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else if (push && ((^dq_in) != dq_par)) par_err <= 1'b1;
  end
`endif

  rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (dq_in),
    .pop       (pop),
    .pop_data  (rd_data),
    .count     (fifo_count)
  );

endmodule
